// File: rtl/fanout_pipe_buffer.sv
// DEPTH-stage valid/ready pipeline whose last stage broadcasts to NUM_LOADS independent consumers.
// Optional macro FANOUT_PIPE_SKID_EN: each stage becomes a two-entry skid buffer with registered ready.
module fanout_pipe_buffer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int NUM_LOADS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic [NUM_LOADS-1:0]         out_valid,
    input  logic [NUM_LOADS-1:0]         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(2*DEPTH+2)-1:0] occupancy
);
    localparam int OCC_W = $clog2(2*DEPTH+2);

    logic [DEPTH-1:0]     r_vld;
    logic [WIDTH-1:0]     r_data [DEPTH];
    logic [NUM_LOADS-1:0] r_taken;
    logic [OCC_W-1:0]     r_occ;

    logic [DEPTH-1:0]     w_stg_rdy;
    logic [DEPTH-1:0]     w_up_vld;
    logic [WIDTH-1:0]     w_up_data [DEPTH];
    logic                 w_head_vld;
    logic                 w_retire;
    logic                 w_accept;

    // Head of the pipe feeds the fork; a load that already took the word is masked off.
    assign w_head_vld = r_vld[DEPTH-1];
    assign out_valid  = {NUM_LOADS{w_head_vld}} & ~r_taken;
    assign w_retire   = w_head_vld & (&(r_taken | out_ready));
    assign out_data   = r_data[DEPTH-1];

    assign in_ready   = w_stg_rdy[0];
    assign w_accept   = in_valid & in_ready;
    assign occupancy  = r_occ;

    // Stage k is fed by stage k-1; stage 0 is fed by the driver.
    assign w_up_vld = DEPTH'({r_vld, in_valid});

    always_comb begin
        w_up_data[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_up_data[k] = r_data[k-1];
        end
    end

`ifdef FANOUT_PIPE_SKID_EN
    logic [DEPTH-1:0] r_skv;
    logic [WIDTH-1:0] r_skd [DEPTH];
    logic [DEPTH-1:0] w_dn_rdy;

    // A stage stays ready while its skid slot is free, so every ready is a flop output.
    assign w_stg_rdy = ~r_skv;
    assign w_dn_rdy  = DEPTH'({w_retire, w_stg_rdy} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_skv <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (r_skv[k]) begin
                    if (w_dn_rdy[k]) begin
                        r_skv[k] <= 1'b0;
                    end
                end else if (!r_vld[k] || w_dn_rdy[k]) begin
                    r_vld[k] <= w_up_vld[k];
                end else if (w_up_vld[k]) begin
                    r_skv[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (r_skv[k]) begin
                if (w_dn_rdy[k]) begin
                    r_data[k] <= r_skd[k];
                end
            end else if (!r_vld[k] || w_dn_rdy[k]) begin
                if (w_up_vld[k]) begin
                    r_data[k] <= w_up_data[k];
                end
            end else if (w_up_vld[k]) begin
                r_skd[k] <= w_up_data[k];
            end
        end
    end
`else
    // Ready ripples back from the fork: a stage can load if it or any stage ahead has a hole.
    always_comb begin
        logic v_acc;
        w_stg_rdy = '0;
        v_acc     = w_retire;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            v_acc        = v_acc | ~r_vld[k];
            w_stg_rdy[k] = v_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_stg_rdy[k]) begin
                    r_vld[k] <= w_up_vld[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (w_stg_rdy[k] && w_up_vld[k]) begin
                r_data[k] <= w_up_data[k];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken <= '0;
        end else if (w_retire) begin
            r_taken <= '0;
        end else begin
            r_taken <= r_taken | (out_valid & out_ready);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (w_accept && !w_retire) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_accept && w_retire) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_fanout_pipe_buffer.sv
// Directed bench for fanout_pipe_buffer: three instances (2 loads, 3 loads, single-load DEPTH=1).
module tb_fanout_pipe_buffer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       a_in_valid, a_in_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_out_valid, a_out_ready;
    logic [2:0] a_occ;

    logic       b_in_valid, b_in_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [2:0] b_out_valid, b_out_ready;
    logic [2:0] b_occ;

    logic       c_in_valid, c_in_ready;
    logic [7:0] c_in_data, c_out_data;
    logic [0:0] c_out_valid, c_out_ready;
    logic [1:0] c_occ;

    fanout_pipe_buffer #(.WIDTH(8), .DEPTH(2), .NUM_LOADS(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    fanout_pipe_buffer #(.WIDTH(8), .DEPTH(2), .NUM_LOADS(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    fanout_pipe_buffer #(.WIDTH(8), .DEPTH(1), .NUM_LOADS(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 2'b00;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 3'b000;
        c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;
        #2;
        checks++; if (a_out_valid !== 2'b00) begin failures++; $display("FAIL reset_a_out_valid actual=%b required=00", a_out_valid); end
        checks++; if (a_occ !== 3'd0) begin failures++; $display("FAIL reset_a_occ actual=%0d required=0", a_occ); end
        checks++; if (b_out_valid !== 3'b000) begin failures++; $display("FAIL reset_b_out_valid actual=%b required=000", b_out_valid); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready actual=%b required=1", a_in_ready); end
        checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_c_in_ready actual=%b required=1", c_in_ready); end
        checks++; if (c_occ !== 2'd0) begin failures++; $display("FAIL post_reset_c_occ actual=%0d required=0", c_occ); end
    endtask

    task automatic test_back_to_back();
        int acc, ret;
        logic [1:0] exp_v;
        a_out_ready = 2'b11;
        for (int i = 0; i < 9; i++) begin
            a_in_valid = (i < 5);
            a_in_data  = 8'(i + 1);
            #1;
            exp_v = (i >= 2 && i < 7) ? 2'b11 : 2'b00;
            acc = (i < 5) ? i : 5;
            ret = (i <= 2) ? 0 : ((i - 2 < 5) ? i - 2 : 5);
            if (i < 5) begin
                checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d actual=%b required=1", i, a_in_ready); end
            end
            checks++; if (a_out_valid !== exp_v) begin failures++; $display("FAIL b2b_out_valid cyc=%0d actual=%b required=%b", i, a_out_valid, exp_v); end
            if (exp_v != 2'b00) begin
                checks++; if (a_out_data !== 8'(i - 1)) begin failures++; $display("FAIL b2b_out_data cyc=%0d actual=%h required=%h", i, a_out_data, 8'(i - 1)); end
            end
            checks++; if (a_occ !== 3'(acc - ret)) begin failures++; $display("FAIL b2b_occ cyc=%0d actual=%0d required=%0d", i, a_occ, acc - ret); end
            tick();
        end
        a_in_valid = 1'b0;
        a_out_ready = 2'b00;
    endtask

    task automatic test_fork();
        logic       vin_t [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] din_t [8] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [2:0] rdy_t [8] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b110, 3'b111, 3'b000};
        logic [2:0] ov_t  [8] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b110, 3'b110, 3'b111, 3'b000};
        logic [7:0] od_t  [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00};
        int         occ_t [8] = '{0, 1, 2, 2, 2, 2, 1, 0};
        for (int i = 0; i < 8; i++) begin
            b_in_valid  = vin_t[i];
            b_in_data   = din_t[i];
            b_out_ready = rdy_t[i];
            #1;
            if (vin_t[i]) begin
                checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL fork_in_ready cyc=%0d actual=%b required=1", i, b_in_ready); end
            end
            checks++; if (b_out_valid !== ov_t[i]) begin failures++; $display("FAIL fork_out_valid cyc=%0d actual=%b required=%b", i, b_out_valid, ov_t[i]); end
            if (ov_t[i] != 3'b000) begin
                checks++; if (b_out_data !== od_t[i]) begin failures++; $display("FAIL fork_out_data cyc=%0d actual=%h required=%h", i, b_out_data, od_t[i]); end
            end
            checks++; if (b_occ !== 3'(occ_t[i])) begin failures++; $display("FAIL fork_occ cyc=%0d actual=%0d required=%0d", i, b_occ, occ_t[i]); end
            tick();
        end
        b_in_valid = 1'b0;
        b_out_ready = 3'b000;
    endtask

    task automatic test_fill();
        int sent = 0;
        int rcv  = 0;
`ifdef FANOUT_PIPE_SKID_EN
        int cap  = 4;
`else
        int cap  = 2;
`endif
        a_out_ready = 2'b00;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'hA0 + sent);
            #1;
            checks++; if (a_in_ready !== (sent < cap)) begin failures++; $display("FAIL fill_in_ready cyc=%0d actual=%b required=%b", i, a_in_ready, (sent < cap)); end
            checks++; if (a_occ !== 3'(sent)) begin failures++; $display("FAIL fill_occ cyc=%0d actual=%0d required=%0d", i, a_occ, sent); end
            if (a_in_ready) sent++;
            tick();
        end
        checks++; if (a_occ !== 3'(cap)) begin failures++; $display("FAIL fill_occ_full actual=%0d required=%0d", a_occ, cap); end
        checks++; if (a_out_valid !== 2'b11) begin failures++; $display("FAIL fill_head_valid actual=%b required=11", a_out_valid); end
        a_out_ready = 2'b11;
        for (int i = 0; i < 30 && !(rcv == 6 && sent == 6); i++) begin
            a_in_valid = (sent < 6);
            a_in_data  = 8'(8'hA0 + sent);
            #1;
            if (a_out_valid == 2'b11) begin
                checks++; if (a_out_data !== 8'(8'hA0 + rcv)) begin failures++; $display("FAIL drain_data idx=%0d actual=%h required=%h", rcv, a_out_data, 8'(8'hA0 + rcv)); end
                rcv++;
            end else begin
                checks++; if (a_out_valid !== 2'b00) begin failures++; $display("FAIL drain_split_valid actual=%b required=00", a_out_valid); end
            end
            if (a_in_valid && a_in_ready) sent++;
            tick();
        end
        a_in_valid = 1'b0;
        a_out_ready = 2'b00;
        #1;
        checks++; if (rcv !== 6) begin failures++; $display("FAIL drain_count actual=%0d required=6", rcv); end
        checks++; if (a_occ !== 3'd0) begin failures++; $display("FAIL drain_occ actual=%0d required=0", a_occ); end
        tick();
    endtask

    task automatic test_same_cycle();
        logic       vin_t [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] din_t [6] = '{8'h31, 8'h00, 8'h32, 8'h00, 8'h00, 8'h00};
        logic [1:0] rdy_t [6] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
        logic [1:0] ov_t  [6] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
        logic [7:0] od_t  [6] = '{8'h00, 8'h00, 8'h31, 8'h00, 8'h32, 8'h00};
        int         occ_t [6] = '{0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            a_in_valid  = vin_t[i];
            a_in_data   = din_t[i];
            a_out_ready = rdy_t[i];
            #1;
            checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL same_in_ready cyc=%0d actual=%b required=1", i, a_in_ready); end
            checks++; if (a_out_valid !== ov_t[i]) begin failures++; $display("FAIL same_out_valid cyc=%0d actual=%b required=%b", i, a_out_valid, ov_t[i]); end
            if (ov_t[i] != 2'b00) begin
                checks++; if (a_out_data !== od_t[i]) begin failures++; $display("FAIL same_out_data cyc=%0d actual=%h required=%h", i, a_out_data, od_t[i]); end
            end
            checks++; if (a_occ !== 3'(occ_t[i])) begin failures++; $display("FAIL same_occ cyc=%0d actual=%0d required=%0d", i, a_occ, occ_t[i]); end
            tick();
        end
        a_in_valid = 1'b0;
        a_out_ready = 2'b00;
    endtask

    task automatic test_reset_mid();
        a_in_valid = 1'b1; a_in_data = 8'h41; a_out_ready = 2'b00;
        tick();
        a_in_data = 8'h42;
        tick();
        a_in_valid = 1'b0; a_out_ready = 2'b01;
        #1;
        checks++; if (a_out_valid !== 2'b11) begin failures++; $display("FAIL rmid_head_valid actual=%b required=11", a_out_valid); end
        checks++; if (a_out_data !== 8'h41) begin failures++; $display("FAIL rmid_head_data actual=%h required=41", a_out_data); end
        tick();
        a_out_ready = 2'b00;
        #1;
        checks++; if (a_out_valid !== 2'b10) begin failures++; $display("FAIL rmid_taken_valid actual=%b required=10", a_out_valid); end
        checks++; if (a_occ !== 3'd2) begin failures++; $display("FAIL rmid_occ_before actual=%0d required=2", a_occ); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 2'b00) begin failures++; $display("FAIL rmid_async_valid actual=%b required=00", a_out_valid); end
        checks++; if (a_occ !== 3'd0) begin failures++; $display("FAIL rmid_async_occ actual=%0d required=0", a_occ); end
        tick();
        rst_n = 1'b1;
        a_out_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (a_out_valid !== 2'b00) begin failures++; $display("FAIL rmid_no_replay cyc=%0d actual=%b required=00", i, a_out_valid); end
            checks++; if (a_occ !== 3'd0) begin failures++; $display("FAIL rmid_occ_after cyc=%0d actual=%0d required=0", i, a_occ); end
            tick();
        end
        a_out_ready = 2'b00;
    endtask

    task automatic test_single_load();
        int acc, ret;
        logic exp_v;
        c_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_in_valid = (i < 3);
            c_in_data  = 8'(8'h11 + i);
            #1;
            exp_v = (i >= 1 && i < 4);
            acc = (i < 3) ? i : 3;
            ret = (i <= 1) ? 0 : ((i - 1 < 3) ? i - 1 : 3);
            checks++; if (c_out_valid !== exp_v) begin failures++; $display("FAIL single_out_valid cyc=%0d actual=%b required=%b", i, c_out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (c_out_data !== 8'(8'h10 + i)) begin failures++; $display("FAIL single_out_data cyc=%0d actual=%h required=%h", i, c_out_data, 8'(8'h10 + i)); end
            end
            checks++; if (c_occ !== 2'(acc - ret)) begin failures++; $display("FAIL single_occ cyc=%0d actual=%0d required=%0d", i, c_occ, acc - ret); end
            tick();
        end
        c_in_valid = 1'b0;
        c_out_ready = 1'b0;
    endtask

    task automatic test_random_stream();
        int sent = 0;
        int exp0 = 0;
        int exp1 = 0;
        int cyc  = 0;
`ifdef FANOUT_PIPE_SKID_EN
        logic rdy_early;
`endif
        while ((exp0 < 256 || exp1 < 256) && cyc < 4000) begin
            a_in_valid = (sent < 256);
            a_in_data  = 8'(sent);
`ifdef FANOUT_PIPE_SKID_EN
            a_out_ready = 2'($urandom_range(0, 3));
            #1;
            rdy_early = a_in_ready;
            a_out_ready = 2'($urandom_range(0, 3));
            #1;
            checks++; if (a_in_ready !== rdy_early) begin failures++; $display("FAIL rand_in_ready_glitch cyc=%0d actual=%b required=%b", cyc, a_in_ready, rdy_early); end
`else
            a_out_ready = 2'($urandom_range(0, 3));
            #1;
`endif
            if (a_out_valid[0] && a_out_ready[0]) begin
                checks++; if (a_out_data !== 8'(exp0)) begin failures++; $display("FAIL rand_load0 idx=%0d actual=%h required=%h", exp0, a_out_data, 8'(exp0)); end
                exp0++;
            end
            if (a_out_valid[1] && a_out_ready[1]) begin
                checks++; if (a_out_data !== 8'(exp1)) begin failures++; $display("FAIL rand_load1 idx=%0d actual=%h required=%h", exp1, a_out_data, 8'(exp1)); end
                exp1++;
            end
            if (a_in_valid && a_in_ready) sent++;
            tick();
            cyc++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 2'b00;
        checks++; if (exp0 !== 256) begin failures++; $display("FAIL rand_load0_count actual=%0d required=256", exp0); end
        checks++; if (exp1 !== 256) begin failures++; $display("FAIL rand_load1_count actual=%0d required=256", exp1); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_fork();
        test_fill();
        test_same_cycle();
        test_reset_mid();
        test_single_load();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
